// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. One byte is taken per grant, handed to the transmitter with a
// single-cycle data_valid pulse, and the frame is tracked through busy before
// the next grant is made.
//
// Ports
//   clk          system clock, rising edge active
//   rst          asynchronous reset, active low
//   req_valid    per-requester byte pending
//   req_data     requester i byte in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_par_en   per-requester parity enable
//   req_par_typ  per-requester parity type (0 even, 1 odd)
//   req_ack      one-hot, one-cycle pulse: byte consumed
//   p_data       byte to the transmitter
//   par_en       parity enable to the transmitter
//   par_typ      parity type to the transmitter
//   data_valid   one-cycle start pulse to the transmitter
//   busy         transmitter busy flag
//   gnt_id       index of the current or last granted requester
//   active       high from grant until the frame completes
//   tx_err       one-cycle pulse: busy never rose after data_valid
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; arbitrate when a request is pending and
//           | the transmitter is not busy
// ISSUE     | data_valid and req_ack are high for this single cycle
// WAIT_BUSY | waiting for the transmitter to acknowledge the frame by busy
// WAIT_DONE | frame in progress; return to IDLE when busy falls

module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 8,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    input  logic [NUM_REQ-1:0]            req_par_typ,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         p_data,
    output logic                          par_en,
    output logic                          par_typ,
    output logic                          data_valid,
    input  logic                          busy,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          active,
    output logic                          tx_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    int                 idx;

    // Search upward from ptr+1 with wrap; the last granted requester is
    // visited last, which gives every other pending requester a turn first.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= ID_W'(NUM_REQ - 1);
            cnt        <= '0;
            req_ack    <= '0;
            p_data     <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            data_valid <= 1'b0;
            gnt_id     <= '0;
            active     <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            req_ack    <= '0;
            tx_err     <= 1'b0;
            case (state)
                IDLE: begin
                    // busy high here means someone else owns the line
                    if (win_found && !busy) begin
                        p_data     <= req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                        par_en     <= req_par_en[win_id];
                        par_typ    <= req_par_typ[win_id];
                        gnt_id     <= win_id;
                        ptr        <= win_id;
                        active     <= 1'b1;
                        data_valid <= 1'b1;
                        req_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // the byte is dropped, not retried
                        tx_err <= 1'b1;
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DATA_WIDTH   = 8;
    localparam int BUSY_TIMEOUT = 4;
    localparam int FRAME        = 10;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_par_en = '0;
    logic [NUM_REQ-1:0]            req_par_typ = '0;
    logic [NUM_REQ-1:0]            req_ack;
    logic [DATA_WIDTH-1:0]         p_data;
    logic                          par_en;
    logic                          par_typ;
    logic                          data_valid;
    logic                          busy;
    logic [1:0]                    gnt_id;
    logic                          active;
    logic                          tx_err;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int ack_cnt = 0;

    // transmitter model
    logic model_en = 1'b1;
    logic ext_busy = 1'b0;
    logic m_busy;
    logic m_pend;
    int   m_cnt;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .req_ack(req_ack), .p_data(p_data), .par_en(par_en), .par_typ(par_typ),
        .data_valid(data_valid), .busy(busy), .gnt_id(gnt_id),
        .active(active), .tx_err(tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (|req_ack) ack_cnt++;

    assign busy = m_busy | ext_busy;

    // busy rises two edges after the data_valid grant edge and stays high FRAME cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_pend <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (m_busy) begin
                if (m_cnt == 1) m_busy <= 1'b0;
                m_cnt <= m_cnt - 1;
            end else if (m_pend) begin
                m_busy <= 1'b1;
                m_cnt  <= FRAME;
                m_pend <= 1'b0;
            end
            if (data_valid && model_en) m_pend <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input string tag, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (data_valid) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_dv_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!active && !busy) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int c1, c2, c3, t, a0, rel, seen, k;

        // reset state
        #12;
        check("rst_outputs", {req_ack, p_data, par_en, par_typ, data_valid, gnt_id, active, tx_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single request
        req_valid        = 4'b0010;
        req_data[15:8]   = 8'hA5;
        req_par_en[1]    = 1'b1;
        req_par_typ[1]   = 1'b1;
        wait_dv("single", c1);
        check("single_ack",    32'(req_ack), 32'h2);
        check("single_pdata",  32'(p_data),  32'hA5);
        check("single_par",    {30'd0, par_en, par_typ}, 32'h3);
        check("single_gnt",    32'(gnt_id),  32'd1);
        check("single_active", 32'(active),  32'd1);
        @(negedge clk);
        req_valid = '0;
        check("single_pulse", {30'd0, data_valid, |req_ack}, 32'd0);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        check("single_busy_seen", 32'(seen), 32'd1);
        check("single_active_busy", 32'(active), 32'd1);
        wait_idle("single");
        check("single_hold", {22'd0, p_data, gnt_id}, {22'd0, 8'hA5, 2'd1});

        // fairness from a fresh pointer
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        req_par_en  = 4'b0101;
        req_par_typ = 4'b0011;
        req_valid   = 4'b1111;
        a0 = ack_cnt;
        for (int g = 0; g < 8; g++) begin
            wait_dv("fair", c1);
            k = g % 4;
            check("fair_gnt",   32'(gnt_id),  32'(k));
            check("fair_ack",   32'(req_ack), 32'(1 << k));
            check("fair_pdata", 32'(p_data),  32'(8'h10 + k));
            check("fair_par",   {30'd0, par_en, par_typ}, {30'd0, req_par_en[k], req_par_typ[k]});
        end
        @(negedge clk);
        check("fair_ack_count", 32'(ack_cnt - a0), 32'd8);

        // back-to-back from requester 2; DV pulses FRAME+4 edges apart
        req_valid      = 4'b0100;
        req_data[23:16] = 8'h01;
        wait_dv("b2b1", c1);
        check("b2b1_pdata", 32'(p_data), 32'h01);
        @(negedge clk);
        req_data[23:16] = 8'h02;
        wait_dv("b2b2", c2);
        check("b2b2_pdata", 32'(p_data), 32'h02);
        check("b2b2_gap",   32'(c2 - c1), 32'(FRAME + 4));
        check("b2b2_busy",  32'(busy),   32'd0);
        @(negedge clk);
        req_data[23:16] = 8'h03;
        wait_dv("b2b3", c3);
        check("b2b3_pdata", 32'(p_data), 32'h03);
        check("b2b3_gap",   32'(c3 - c2), 32'(FRAME + 4));
        @(negedge clk);
        req_valid = '0;
        wait_idle("b2b");

        // timeout: pointer at 2, so requester 0 wins, then requester 1
        model_en = 1'b0;
        req_data[7:0]  = 8'h77;
        req_data[15:8] = 8'h88;
        req_valid = 4'b0011;
        wait_dv("to", c1);
        check("to_gnt", 32'(gnt_id), 32'd0);
        @(negedge clk);
        req_valid = 4'b0010;
        t = -1;
        for (int n = 0; n < 20; n++) begin
            if (tx_err) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check("to_err_time", 32'(t - c1), 32'(BUSY_TIMEOUT + 1));
        check("to_active",   32'(active), 32'd0);
        model_en = 1'b1;
        wait_dv("to_next", c2);
        check("to_next_gnt",   32'(gnt_id), 32'd1);
        check("to_next_pdata", 32'(p_data), 32'h88);
        check("to_next_time",  32'(c2 - t), 32'd1);
        check("to_err_pulse",  32'(tx_err), 32'd0);
        @(negedge clk);
        req_valid = '0;
        wait_idle("to");

        // external busy holds off the grant
        ext_busy = 1'b1;
        req_data[31:24] = 8'hC3;
        req_valid = 4'b1000;
        a0 = ack_cnt;
        repeat (6) @(negedge clk);
        check("ext_no_ack",    32'(ack_cnt - a0), 32'd0);
        check("ext_no_active", 32'(active), 32'd0);
        ext_busy = 1'b0;
        rel = cyc;
        wait_dv("ext", c1);
        check("ext_time",  32'(c1 - rel), 32'd1);
        check("ext_gnt",   32'(gnt_id),  32'd3);
        check("ext_ack",   32'(req_ack), 32'h8);
        check("ext_pdata", 32'(p_data),  32'hC3);
        @(negedge clk);
        req_valid = '0;
        wait_idle("ext");

        // reset mid-frame; pointer returns to NUM_REQ-1 so 0 beats 3
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        wait_dv("rstmf", c1);
        check("rstmf_gnt", 32'(gnt_id), 32'd0);
        @(negedge clk);
        req_valid = '0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        @(negedge clk);
        check("rstmf_in_frame", {30'd0, seen[0], active}, 32'h3);
        rst = 1'b0;
        #1;
        check("rstmf_outputs", {req_ack, p_data, par_en, par_typ, data_valid, gnt_id, active, tx_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req_data[7:0]   = 8'h11;
        req_data[31:24] = 8'h33;
        req_valid = 4'b1001;
        wait_dv("rstmf_tie", c1);
        check("rstmf_tie_gnt",   32'(gnt_id), 32'd0);
        check("rstmf_tie_pdata", 32'(p_data), 32'h11);
        @(negedge clk);
        req_valid = '0;
        wait_idle("rstmf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
